// File: rtl/watch_pkg.sv
// Shared field widths, moduli and the per-field adjust bundle for the watch
// time-of-day datapath.
package watch_pkg;
    localparam int CSEC_W   = 7;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef struct packed {
        logic hour;
        logic min;
        logic sec;
    } adj_t;
endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) field counter with synchronous load; wrap flags the carry out
// of this increment so fields can be chained.
module mod_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] val,
    output logic         wrap
);
    logic [W-1:0] val_q, val_d;

    assign wrap = inc && (val_q == W'(MAX));
    assign val  = val_q;

    always_comb begin
        val_d = val_q;
        if (load)
            val_d = load_val;
        else if (inc)
            val_d = wrap ? '0 : val_q + W'(1);
    end

    always_ff @(posedge clk) begin
        val_q <= val_d;
    end
endmodule

// File: rtl/watch_time_counter.sv
// Time-of-day counter: tick-driven carry chain across csec/sec/min/hour with
// per-field adjust; adjusts that collide with a tick are deferred one non-tick cycle.
module watch_time_counter
    import watch_pkg::*;
#(
    parameter int TICK_HZ   = 100,
    parameter int INIT_HOUR = 12,
    parameter int INIT_MIN  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tick,
    input  logic              i_clear,
    input  logic              i_inc_sec,
    input  logic              i_inc_min,
    input  logic              i_inc_hour,
    output logic [CSEC_W-1:0] o_csec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_sec_pulse,
    output logic              o_day_pulse
);
    logic load, tick;
    adj_t req, apply, pend_q, pend_d;
    logic inc_csec, inc_sec, inc_min, inc_hour;
    logic wrap_csec, wrap_sec, wrap_min, wrap_hour;
    logic sec_pulse_q, sec_pulse_d, day_pulse_q, day_pulse_d;

    // Reset shares the clear load path; the flops below also reset explicitly.
    assign load = !rst_n || i_clear;
    assign tick = !load && i_tick;
    assign req  = '{hour: i_inc_hour, min: i_inc_min, sec: i_inc_sec};

    always_comb begin
        apply    = '0;
        pend_d   = '0;
        inc_csec = tick;
        inc_sec  = 1'b0;
        inc_min  = 1'b0;
        inc_hour = 1'b0;
        if (!load) begin
            if (i_tick) begin
                pend_d   = pend_q | req;
                inc_sec  = wrap_csec;
                inc_min  = wrap_sec;
                inc_hour = wrap_min;
            end else begin
                // A new pulse on an already-pending field merges into one increment.
                apply    = pend_q | req;
                inc_sec  = apply.sec;
                inc_min  = apply.min;
                inc_hour = apply.hour;
            end
        end
        sec_pulse_d = tick && wrap_csec;
        day_pulse_d = tick && wrap_hour;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q      <= '0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    mod_counter #(.MAX(TICK_HZ-1), .W(CSEC_W)) u_csec (
        .clk(clk), .inc(inc_csec), .load(load), .load_val('0),
        .val(o_csec), .wrap(wrap_csec));
    mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk(clk), .inc(inc_sec), .load(load), .load_val('0),
        .val(o_sec), .wrap(wrap_sec));
    mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk(clk), .inc(inc_min), .load(load), .load_val(MIN_W'(INIT_MIN)),
        .val(o_min), .wrap(wrap_min));
    mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk(clk), .inc(inc_hour), .load(load), .load_val(HOUR_W'(INIT_HOUR)),
        .val(o_hour), .wrap(wrap_hour));

    assign o_sec_pulse = sec_pulse_q;
    assign o_day_pulse = day_pulse_q;
endmodule

// File: tb/tb_watch_time_counter.sv
// Scoreboard bench for watch_time_counter: a behavioural time model pushes the
// expected outputs per driven cycle; they are popped and compared after the edge.
module tb_watch_time_counter;
    logic       clk = 1'b0;
    logic       rst_n, i_tick, i_clear, i_inc_sec, i_inc_min, i_inc_hour;
    logic [6:0] o_csec;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic       o_sec_pulse, o_day_pulse;

    always #5 clk = ~clk;

    watch_time_counter dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_clear(i_clear),
        .i_inc_sec(i_inc_sec), .i_inc_min(i_inc_min), .i_inc_hour(i_inc_hour),
        .o_csec(o_csec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
        .o_sec_pulse(o_sec_pulse), .o_day_pulse(o_day_pulse));

    typedef struct {
        int csec, sec, min, hour, sp, dp;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_err = 0;
    int m_cs = 0, m_s = 0, m_m = 0, m_h = 0;
    bit p_s = 0, p_m = 0, p_h = 0;
    int sp_cnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic cyc(input bit rst, input bit tk, input bit clr,
                       input bit is, input bit im, input bit ih);
        exp_t e;
        int sp = 0, dp = 0;
        rst_n = !rst; i_tick = tk; i_clear = clr;
        i_inc_sec = is; i_inc_min = im; i_inc_hour = ih;
        if (rst || clr) begin
            m_cs = 0; m_s = 0; m_m = 0; m_h = 12;
            p_s = 0; p_m = 0; p_h = 0;
        end else if (tk) begin
            m_cs++;
            if (m_cs == 100) begin
                m_cs = 0; m_s++; sp = 1;
                if (m_s == 60) begin
                    m_s = 0; m_m++;
                    if (m_m == 60) begin
                        m_m = 0; m_h++;
                        if (m_h == 24) begin m_h = 0; dp = 1; end
                    end
                end
            end
            p_s |= is; p_m |= im; p_h |= ih;
        end else begin
            if (is || p_s) m_s = (m_s + 1) % 60;
            if (im || p_m) m_m = (m_m + 1) % 60;
            if (ih || p_h) m_h = (m_h + 1) % 24;
            p_s = 0; p_m = 0; p_h = 0;
        end
        e = '{m_cs, m_s, m_m, m_h, sp, dp};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("csec", int'(o_csec), e.csec);
        chk("sec", int'(o_sec), e.sec);
        chk("min", int'(o_min), e.min);
        chk("hour", int'(o_hour), e.hour);
        chk("sec_pulse", int'(o_sec_pulse), e.sp);
        chk("day_pulse", int'(o_day_pulse), e.dp);
        if (o_sec_pulse) sp_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; i_tick = 0; i_clear = 0;
        i_inc_sec = 0; i_inc_min = 0; i_inc_hour = 0;
        @(negedge clk);

        // Reset with tick held high
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
        chk("rst_hour", int'(o_hour), 12);
        chk("rst_min", int'(o_min), 0);
        chk("rst_csec", int'(o_csec), 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("first_tick_csec", int'(o_csec), 1);

        // Preload 23:59:59.99 then full carry
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 99; i++) cyc(0, 1, 0, 0, 0, 0);
        chk("pre_hour", int'(o_hour), 23);
        chk("pre_csec", int'(o_csec), 99);
        cyc(0, 1, 0, 0, 0, 0);
        chk("carry_hour", int'(o_hour), 0);
        chk("carry_sec", int'(o_sec), 0);
        chk("carry_day", int'(o_day_pulse), 1);
        chk("carry_secp", int'(o_sec_pulse), 1);
        idle(1);
        chk("day_one_cycle", int'(o_day_pulse), 0);

        // Minute adjust wrap, no carry into hour
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 59; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("adj_min59", int'(o_min), 59);
        cyc(0, 0, 0, 0, 1, 0);
        chk("adj_min_wrap", int'(o_min), 0);
        chk("adj_hour_keep", int'(o_hour), 12);
        chk("adj_no_secp", int'(o_sec_pulse), 0);

        // Multiple fields adjusted together
        cyc(0, 0, 0, 1, 1, 1);
        chk("multi_hour", int'(o_hour), 13);

        // Collisions
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        chk("coll_csec", int'(o_csec), 6);
        chk("coll_hour_defer", int'(o_hour), 12);
        idle(1);
        chk("coll_hour_land", int'(o_hour), 13);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        idle(1);
        chk("coll_twice_once", int'(o_hour), 14);
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("pend_plus_pulse", int'(o_min), 1);

        // Clear dominance
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0, 0);
        idle(2);
        chk("clr_sec", int'(o_sec), 0);
        chk("clr_csec", int'(o_csec), 0);
        chk("clr_hour", int'(o_hour), 12);

        // Back-to-back ticks
        cyc(0, 0, 1, 0, 0, 0);
        sp_cnt = 0;
        for (int i = 0; i < 250; i++) cyc(0, 1, 0, 0, 0, 0);
        chk("b2b_sec", int'(o_sec), 2);
        chk("b2b_csec", int'(o_csec), 50);
        chk("b2b_secp_cnt", sp_cnt, 2);

        // Reset mid-pending discards the deferred adjust
        cyc(0, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        chk("rst_pend_sec", int'(o_sec), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
